// File: rtl/zrle_engine_param_if.sv
// Stream bundle for zrle_engine_param: raw words in, encoded tokens out.
interface zrle_engine_param_if #(
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned OUT_W  = DATA_W + 4;
    localparam int unsigned SIZE_W = $clog2(OUT_W + 1);

    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              sop_i;
    logic              eop_i;
    logic              ready_o;
    logic [OUT_W-1:0]  data_o;
    logic [SIZE_W-1:0] size_o;
    logic              sop_o;
    logic              eop_o;
    logic              valid_o;
    logic              ready_i;

    // Encoder side.
    modport slave (
        input  data_i, valid_i, sop_i, eop_i, ready_i,
        output ready_o, data_o, size_o, sop_o, eop_o, valid_o
    );

    // Source of words and sink of tokens.
    modport master (
        output data_i, valid_i, sop_i, eop_i, ready_i,
        input  ready_o, data_o, size_o, sop_o, eop_o, valid_o
    );
endinterface

// File: rtl/zrle_engine_param.sv
// Parametrised zero-run-length encoder: words become bitmask/symbol tokens,
// consecutive all-zero words are merged into run tokens. Registered output
// with a one-entry pending slot for the token that follows a run flush.
// Requires DATA_W % SYM_W == 0 and 2 <= DATA_W/SYM_W <= SYM_W.
module zrle_engine_param #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned SYM_W  = 16,
    parameter int unsigned RUN_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    zrle_engine_param_if.slave zrle_io
);
    localparam int unsigned N      = DATA_W / SYM_W;
    localparam int unsigned OUT_W  = DATA_W + 4;
    localparam int unsigned SIZE_W = $clog2(OUT_W + 1);
    localparam int unsigned WIDE_W = 2 + N + DATA_W;

    localparam logic [SIZE_W-1:0] RunSize  = SIZE_W'(2 + RUN_W);
    localparam logic [SIZE_W-1:0] FullSize = SIZE_W'(2 + DATA_W);

    // RUN token carrying count-1 in the field.
    function automatic logic [OUT_W-1:0] run_tok(input logic [RUN_W-1:0] field);
        return {2'b00, field, {(OUT_W - 2 - RUN_W){1'b0}}};
    endfunction

    // Unprefixed tokens are at most OUT_W-2 bits, so the dropped LSBs are zero.
    function automatic logic [OUT_W-1:0] with_prefix(input logic [OUT_W-1:0] tok,
                                                     input logic             pfx);
        return pfx ? {2'b01, tok[OUT_W-1:2]} : tok;
    endfunction

    function automatic logic [SIZE_W-1:0] size_prefix(input logic [SIZE_W-1:0] sz,
                                                      input logic              pfx);
        return pfx ? sz + SIZE_W'(2) : sz;
    endfunction

    // State
    logic [OUT_W-1:0]  data_q, data_d, pend_data_q, pend_data_d;
    logic [SIZE_W-1:0] size_q, size_d, pend_size_q, pend_size_d;
    logic              valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic              pend_v_q, pend_v_d, pend_sop_q, pend_sop_d, pend_eop_q, pend_eop_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic              run_sop_q, run_sop_d;

    // Word encoding
    logic [N-1:0]      mask;
    logic              is_zero;
    logic [OUT_W-1:0]  word_tok;
    logic [SIZE_W-1:0] word_size;
    logic [DATA_W-1:0] packed_syms;
    logic [WIDE_W-1:0] part_wide;
    int unsigned       nz;

    // Token selection
    logic              out_free, ready, accept, run_empty, new_sop;
    logic              emit, emit_sop, emit_eop;
    logic [OUT_W-1:0]  emit_tok;
    logic [SIZE_W-1:0] emit_size;
    logic              pend_load, pl_sop, pl_eop;
    logic [OUT_W-1:0]  pl_tok;
    logic [SIZE_W-1:0] pl_size;

    assign out_free = !valid_q | zrle_io.ready_i;
    assign ready    = !pend_v_q & out_free;
    assign accept   = zrle_io.valid_i & ready;

    assign zrle_io.ready_o = ready;
    assign zrle_io.data_o  = data_q;
    assign zrle_io.size_o  = size_q;
    assign zrle_io.sop_o   = sop_q;
    assign zrle_io.eop_o   = eop_q;
    assign zrle_io.valid_o = valid_q;

    // Symbol mask and PART/FULL encoding of the incoming word.
    always_comb begin
        mask        = '0;
        packed_syms = '0;
        nz          = 0;
        for (int i = 0; i < int'(N); i++) begin
            mask[i] = |zrle_io.data_i[i*SYM_W +: SYM_W];
        end
        // Gather nonzero symbols highest index first, then left-justify.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                packed_syms = {packed_syms[DATA_W-SYM_W-1:0], zrle_io.data_i[i*SYM_W +: SYM_W]};
                nz++;
            end
        end
        packed_syms = packed_syms << ((N - nz) * SYM_W);
        part_wide   = {2'b10, mask, packed_syms};
        is_zero     = (mask == '0);
        if (mask == '1) begin
            word_tok  = {2'b11, zrle_io.data_i, 2'b00};
            word_size = FullSize;
        end else begin
            word_tok  = part_wide[WIDE_W-1 -: OUT_W];
            word_size = SIZE_W'(2 + N + nz * SYM_W);
        end
    end

    // Run tracking and choice of emitted / pended token for an accepted word.
    always_comb begin
        emit      = 1'b0;
        emit_tok  = '0;
        emit_size = '0;
        emit_sop  = 1'b0;
        emit_eop  = 1'b0;
        pend_load = 1'b0;
        pl_tok    = '0;
        pl_size   = '0;
        pl_sop    = 1'b0;
        pl_eop    = 1'b0;
        run_cnt_d = run_cnt_q;
        run_sop_d = run_sop_q;
        run_empty = (run_cnt_q == '0);
        new_sop   = run_sop_q | (run_empty & zrle_io.sop_i);
        if (accept) begin
            if (is_zero && (run_empty || !zrle_io.sop_i)) begin
                if (!zrle_io.eop_i) begin
                    if (run_cnt_q == '1) begin
                        // Count reaches 2^RUN_W: close the run now.
                        emit      = 1'b1;
                        emit_tok  = run_tok(run_cnt_q);
                        emit_size = RunSize;
                        emit_sop  = new_sop;
                        run_cnt_d = '0;
                        run_sop_d = 1'b0;
                    end else begin
                        run_cnt_d = run_cnt_q + RUN_W'(1);
                        run_sop_d = new_sop;
                    end
                end else begin
                    emit      = 1'b1;
                    emit_tok  = run_tok(run_cnt_q);
                    emit_size = RunSize;
                    emit_sop  = run_sop_q | zrle_io.sop_i;
                    emit_eop  = 1'b1;
                    run_cnt_d = '0;
                    run_sop_d = 1'b0;
                end
            end else if (run_empty) begin
                emit      = 1'b1;
                emit_tok  = word_tok;
                emit_size = word_size;
                emit_sop  = zrle_io.sop_i;
                emit_eop  = zrle_io.eop_i;
            end else begin
                // Flush the open run first; this word's outcome follows it.
                emit      = 1'b1;
                emit_tok  = run_tok(run_cnt_q - RUN_W'(1));
                emit_size = RunSize;
                emit_sop  = run_sop_q;
                run_cnt_d = '0;
                run_sop_d = 1'b0;
                if (!is_zero) begin
                    pend_load = 1'b1;
                    pl_tok    = word_tok;
                    pl_size   = word_size;
                    pl_sop    = zrle_io.sop_i;
                    pl_eop    = zrle_io.eop_i;
                end else if (!zrle_io.eop_i) begin
                    run_cnt_d = RUN_W'(1);
                    run_sop_d = 1'b1;
                end else begin
                    pend_load = 1'b1;
                    pl_tok    = run_tok('0);
                    pl_size   = RunSize;
                    pl_sop    = 1'b1;
                    pl_eop    = 1'b1;
                end
            end
        end
    end

    // Output register and pending slot next state.
    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        size_d      = size_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        pend_v_d    = pend_v_q;
        pend_data_d = pend_data_q;
        pend_size_d = pend_size_q;
        pend_sop_d  = pend_sop_q;
        pend_eop_d  = pend_eop_q;
        if (out_free) begin
            valid_d = 1'b0;
        end
        if (emit) begin
            valid_d = 1'b1;
            data_d  = with_prefix(emit_tok, emit_sop);
            size_d  = size_prefix(emit_size, emit_sop);
            sop_d   = emit_sop;
            eop_d   = emit_eop;
        end else if (pend_v_q && out_free) begin
            valid_d  = 1'b1;
            data_d   = pend_data_q;
            size_d   = pend_size_q;
            sop_d    = pend_sop_q;
            eop_d    = pend_eop_q;
            pend_v_d = 1'b0;
        end
        if (pend_load) begin
            pend_v_d    = 1'b1;
            pend_data_d = with_prefix(pl_tok, pl_sop);
            pend_size_d = size_prefix(pl_size, pl_sop);
            pend_sop_d  = pl_sop;
            pend_eop_d  = pl_eop;
        end
    end

    // State registers; reset discards any open run and pending token.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            size_q      <= '0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_data_q <= '0;
            pend_size_q <= '0;
            pend_sop_q  <= 1'b0;
            pend_eop_q  <= 1'b0;
            run_cnt_q   <= '0;
            run_sop_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            data_q      <= data_d;
            size_q      <= size_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            pend_v_q    <= pend_v_d;
            pend_data_q <= pend_data_d;
            pend_size_q <= pend_size_d;
            pend_sop_q  <= pend_sop_d;
            pend_eop_q  <= pend_eop_d;
            run_cnt_q   <= run_cnt_d;
            run_sop_q   <= run_sop_d;
        end
    end
endmodule

// File: tb/tb_zrle_engine_param.sv
// Bench for zrle_engine_param (DATA_W=64, SYM_W=16, RUN_W=4): vector table
// plus hand sequences; expected tokens queued at drive time, compared on output.
module tb_zrle_engine_param;
    logic clk;
    logic rst_n;

    zrle_engine_param_if #(.DATA_W(64)) bus ();

    zrle_engine_param #(
        .DATA_W(64),
        .SYM_W (16),
        .RUN_W (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .zrle_io(bus)
    );

    typedef struct {
        logic [67:0] data;
        logic [6:0]  size;
        logic        sop;
        logic        eop;
        int          id;
    } tok_t;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [67:0] exp_data;
        logic [6:0]  exp_size;
        logic        exp_sop;
        logic        exp_eop;
    } vec_t;

    tok_t exp_q[$];
    tok_t mon_e;
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   next_id  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [67:0] d, input logic [6:0] s, input logic so,
                            input logic eo);
        tok_t t;
        t.data = d;
        t.size = s;
        t.sop  = so;
        t.eop  = eo;
        t.id   = next_id;
        next_id++;
        exp_q.push_back(t);
    endtask

    // Present one word and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send_word(input logic [63:0] d, input logic so, input logic eo);
        int waited;
        waited = 0;
        bus.data_i  = d;
        bus.sop_i   = so;
        bus.eop_i   = eo;
        bus.valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.ready_o === 1'b1) break;
            waited++;
            if (waited > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: got ready_o=0 for 50 cycles, required 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.sop_i   = 1'b0;
        bus.eop_i   = 1'b0;
        bus.data_i  = '0;
    endtask

    // Scoreboard: every token taken must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && bus.valid_o && bus.ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_token: got data=%h size=%0d, required no token",
                         bus.data_o, bus.size_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.data_o !== mon_e.data || bus.size_o !== mon_e.size ||
                    bus.sop_o !== mon_e.sop || bus.eop_o !== mon_e.eop) begin
                    n_fail++;
                    $display("FAIL token%0d: got data=%h size=%0d sop=%b eop=%b, required data=%h size=%0d sop=%b eop=%b",
                             mon_e.id, bus.data_o, bus.size_o, bus.sop_o, bus.eop_o,
                             mon_e.data, mon_e.size, mon_e.sop, mon_e.eop);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{64'h0000_0000_0000_1234, 1'b1, 1'b1, 68'h6_1123_4000_0000_0000, 7'd24, 1'b1, 1'b1};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 68'h7_FFFF_FFFF_FFFF_FFFF, 7'd68, 1'b1, 1'b1};
        vecs[2] = '{64'h1234_0000_0000_ABCD, 1'b1, 1'b1, 68'h6_9123_4ABC_D000_0000, 7'd40, 1'b1, 1'b1};
        vecs[3] = '{64'h0001_0002_0003_0000, 1'b0, 1'b1, 68'hB_8000_4000_8000_C000, 7'd54, 1'b0, 1'b1};
        vecs[4] = '{64'h0000_0000_0000_0000, 1'b0, 1'b1, 68'h0_0000_0000_0000_0000, 7'd6,  1'b0, 1'b1};
        vecs[5] = '{64'h0000_0000_0000_0000, 1'b1, 1'b1, 68'h4_0000_0000_0000_0000, 7'd8,  1'b1, 1'b1};
        vecs[6] = '{64'hABCD_0000_0000_0000, 1'b1, 1'b1, 68'h6_8ABC_D000_0000_0000, 7'd24, 1'b1, 1'b1};
        vecs[7] = '{64'h0000_00FF_0000_0000, 1'b0, 1'b0, 68'h9_003F_C000_0000_0000, 7'd22, 1'b0, 1'b0};

        rst_n       = 1'b0;
        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        bus.sop_i   = 1'b0;
        bus.eop_i   = 1'b0;
        bus.ready_i = 1'b1;
        #3;
        check("reset_valid", 68'(bus.valid_o), 68'd0);
        check("reset_data", bus.data_o, 68'd0);
        check("reset_size", 68'(bus.size_o), 68'd0);
        check("reset_sop_eop", 68'({bus.sop_o, bus.eop_o}), 68'd0);
        check("reset_ready", 68'(bus.ready_o), 68'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-word tokens, each emitted one cycle after accept.
        for (int i = 0; i < 8; i++) begin
            push_exp(vecs[i].exp_data, vecs[i].exp_size, vecs[i].exp_sop, vecs[i].exp_eop);
            send_word(vecs[i].data, vecs[i].sop, vecs[i].eop);
            check($sformatf("latency_vec%0d", i), 68'(bus.valid_o), 68'd1);
        end

        // Three-word run flushed by a full word; full word waits one cycle in the slot.
        push_exp(68'h4_2000_0000_0000_0000, 7'd8, 1'b1, 1'b0);
        push_exp(68'hF_FFFF_FFFF_FFFF_FFFC, 7'd66, 1'b0, 1'b1);
        send_word(64'd0, 1'b1, 1'b0);
        send_word(64'd0, 1'b0, 1'b0);
        send_word(64'd0, 1'b0, 1'b0);
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        check("pend_ready_low", 68'(bus.ready_o), 68'd0);
        @(posedge clk);
        #1;
        check("pend_ready_back", 68'(bus.ready_o), 68'd1);

        // Maximum run: 16 zero words give one RUN token, only after the 16th.
        for (int i = 0; i < 15; i++) send_word(64'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("run15_no_token", 68'(bus.valid_o), 68'd0);
        push_exp(68'h3_C000_0000_0000_0000, 7'd6, 1'b0, 1'b0);
        send_word(64'd0, 1'b0, 1'b0);
        check("run16_token", 68'(bus.valid_o), 68'd1);
        // Counter back at zero: a lone eop zero word is RUN(1).
        push_exp(68'h0_0000_0000_0000_0000, 7'd6, 1'b0, 1'b1);
        send_word(64'd0, 1'b0, 1'b1);

        // Zero sop+eop word flushing a run: RUN(2), then pended prefixed RUN(1).
        push_exp(68'h0_4000_0000_0000_0000, 7'd6, 1'b0, 1'b0);
        push_exp(68'h4_0000_0000_0000_0000, 7'd8, 1'b1, 1'b1);
        send_word(64'd0, 1'b0, 1'b0);
        send_word(64'd0, 1'b0, 1'b0);
        send_word(64'd0, 1'b1, 1'b1);

        // Zero sop word mid-run restarts the run with a prefix.
        push_exp(68'h0_4000_0000_0000_0000, 7'd6, 1'b0, 1'b0);
        push_exp(68'h4_1000_0000_0000_0000, 7'd8, 1'b1, 1'b1);
        send_word(64'd0, 1'b0, 1'b0);
        send_word(64'd0, 1'b0, 1'b0);
        send_word(64'd0, 1'b1, 1'b0);
        send_word(64'd0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: token held for 5 cycles, next word blocked until release.
        push_exp(68'h6_1123_4000_0000_0000, 7'd24, 1'b1, 1'b1);
        push_exp(68'h6_8ABC_D000_0000_0000, 7'd24, 1'b1, 1'b1);
        bus.ready_i = 1'b0;
        send_word(64'h0000_0000_0000_1234, 1'b1, 1'b1);
        bus.data_i  = 64'hABCD_0000_0000_0000;
        bus.sop_i   = 1'b1;
        bus.eop_i   = 1'b1;
        bus.valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_data", bus.data_o, 68'h6_1123_4000_0000_0000);
            check("hold_size", 68'(bus.size_o), 68'd24);
            check("hold_valid", 68'(bus.valid_o), 68'd1);
            check("hold_ready", 68'(bus.ready_o), 68'd0);
        end
        @(posedge clk);
        #1;
        bus.ready_i = 1'b1;
        send_word(64'hABCD_0000_0000_0000, 1'b1, 1'b1);
        check("release_next_token", 68'(bus.valid_o), 68'd1);
        repeat (3) @(posedge clk);
        #1;

        // Reset with a flushed run held at the output and a token pending.
        for (int i = 0; i < 5; i++) send_word(64'd0, 1'b0, 1'b0);
        bus.ready_i = 1'b0;
        send_word(64'h0000_0000_0000_0001, 1'b0, 1'b1);
        check("pre_reset_ready", 68'(bus.ready_o), 68'd0);
        check("pre_reset_valid", 68'(bus.valid_o), 68'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 68'(bus.valid_o), 68'd0);
        check("midrst_data", bus.data_o, 68'd0);
        check("midrst_size", 68'(bus.size_o), 68'd0);
        check("midrst_sop_eop", 68'({bus.sop_o, bus.eop_o}), 68'd0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        bus.ready_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_no_token", 68'(bus.valid_o), 68'd0);

        // Reset discards a five-word open run.
        for (int i = 0; i < 5; i++) send_word(64'd0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        push_exp(68'h0_0000_0000_0000_0000, 7'd6, 1'b0, 1'b1);
        send_word(64'd0, 1'b0, 1'b1);

        // Drain the scoreboard within a bounded window.
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("scoreboard_empty", 68'(exp_q.size()), 68'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
